// File: rtl/ram_arbiter.sv
// Arbiter sharing a single-port debug RAM between the host bus and one internal
// requester. Host has priority; a starvation counter bounds the internal wait.
module ram_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_data_i,
  output logic                  host_ack_o,
  output logic [DATA_WIDTH-1:0] host_data_o,
  input  logic                  int_req_i,
  input  logic                  int_we_i,
  input  logic [ADDR_WIDTH-1:0] int_addr_i,
  input  logic [DATA_WIDTH-1:0] int_data_i,
  output logic                  int_ack_o,
  output logic [DATA_WIDTH-1:0] int_data_o,
  output logic                  ram_rd_o,
  output logic                  ram_wr_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [1:0]            grant_o,
  output logic [1:0]            state_o,
  output logic [3:0]            starve_cnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Request/acknowledge contract: a requester holds req/we/addr/data stable
  // until it samples ack high; ack is a single-cycle pulse in DONE, and the
  // requester drops req (or presents a new access) on that same cycle.

  state_t                state_q, state_d;
  logic [3:0]            starve_q, starve_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            grant_q, grant_d;
  logic                  host_ack_q, host_ack_d, int_ack_q, int_ack_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d, int_rdata_q, int_rdata_d;
  logic                  int_win, host_win;

  assign int_win  = int_req_i && (!host_req_i || starve_q == LIMIT);
  assign host_win = host_req_i && !int_win;

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    grant_d      = grant_q;
    host_ack_d   = 1'b0;
    int_ack_d    = 1'b0;
    host_rdata_d = host_rdata_q;
    int_rdata_d  = int_rdata_q;
    case (state_q)
      IDLE: begin
        if (int_win) begin
          state_d  = ACCESS;
          grant_d  = 2'b10;
          rd_d     = !int_we_i;
          wr_d     = int_we_i;
          addr_d   = int_addr_i;
          wdata_d  = int_data_i;
          starve_d = 4'd0;
        end else if (host_win) begin
          state_d = ACCESS;
          grant_d = 2'b01;
          rd_d    = !host_we_i;
          wr_d    = host_we_i;
          addr_d  = host_addr_i;
          wdata_d = host_data_i;
          if (!int_req_i)
            starve_d = 4'd0;
          else if (starve_q < LIMIT)
            starve_d = starve_q + 4'd1;
        end else begin
          starve_d = 4'd0;
        end
      end
      ACCESS: begin
        state_d    = DONE;
        host_ack_d = grant_q[0];
        int_ack_d  = grant_q[1];
        // RAM read data is captured as the strobe cycle ends, so it is valid with ack.
        if (rd_q) begin
          if (grant_q[0]) host_rdata_d = ram_data_i;
          if (grant_q[1]) int_rdata_d  = ram_data_i;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      starve_q     <= 4'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      grant_q      <= 2'b00;
      host_ack_q   <= 1'b0;
      int_ack_q    <= 1'b0;
      host_rdata_q <= '0;
      int_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      grant_q      <= grant_d;
      host_ack_q   <= host_ack_d;
      int_ack_q    <= int_ack_d;
      host_rdata_q <= host_rdata_d;
      int_rdata_q  <= int_rdata_d;
    end
  end

  assign ram_rd_o     = rd_q;
  assign ram_wr_o     = wr_q;
  assign ram_addr_o   = addr_q;
  assign ram_data_o   = wdata_q;
  assign grant_o      = grant_q;
  assign host_ack_o   = host_ack_q;
  assign int_ack_o    = int_ack_q;
  assign host_data_o  = host_rdata_q;
  assign int_data_o   = int_rdata_q;
  assign state_o      = state_q;
  assign starve_cnt_o = starve_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed plus randomised bench for ram_arbiter with a behavioural 32-cell RAM
// and a shadow memory used to predict read data.
module tb_ram_arbiter;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int SL = 4;
  localparam int BOUND = (SL + 1) * 3;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          host_req_i = 1'b0, host_we_i = 1'b0;
  logic [AW-1:0] host_addr_i = '0;
  logic [DW-1:0] host_data_i = '0;
  logic          host_ack_o;
  logic [DW-1:0] host_data_o;
  logic          int_req_i = 1'b0, int_we_i = 1'b0;
  logic [AW-1:0] int_addr_i = '0;
  logic [DW-1:0] int_data_i = '0;
  logic          int_ack_o;
  logic [DW-1:0] int_data_o;
  logic          ram_rd_o, ram_wr_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_o, ram_data_i;
  logic [1:0]    grant_o, state_o;
  logic [3:0]    starve_cnt_o;

  always #5 clk_i = ~clk_i;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_data_i(host_data_i), .host_ack_o(host_ack_o), .host_data_o(host_data_o),
    .int_req_i(int_req_i), .int_we_i(int_we_i), .int_addr_i(int_addr_i),
    .int_data_i(int_data_i), .int_ack_o(int_ack_o), .int_data_o(int_data_o),
    .ram_rd_o(ram_rd_o), .ram_wr_o(ram_wr_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .grant_o(grant_o),
    .state_o(state_o), .starve_cnt_o(starve_cnt_o)
  );

  // Behavioural RAM: asynchronous read, write on the clock edge ending ACCESS.
  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] model_mem [0:31];
  logic          mem_load = 1'b1;
  assign ram_data_i = mem[ram_addr_o];
  always @(posedge clk_i) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h1215 + 16'(i);
    end else if (ram_wr_o) begin
      mem[ram_addr_o] <= ram_data_o;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q [$];
  logic [3:0] starve_exp [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int hw, iw, hw_max, iw_max;
  logic [1:0] g_exp;

  initial begin
    for (int i = 0; i < 32; i++) model_mem[i] = 16'h1215 + 16'(i);
    repeat (2) step();
    mem_load = 1'b0;

    // Reset state
    chk("rst_strobes", 32'({ram_rd_o, ram_wr_o}), 32'd0);
    chk("rst_addr_data", 32'({ram_addr_o, ram_data_o}), 32'd0);
    chk("rst_acks_grant", 32'({host_ack_o, int_ack_o, grant_o}), 32'd0);
    chk("rst_rdata", 32'({host_data_o, int_data_o}), 32'd0);
    chk("rst_state", 32'({state_o, starve_cnt_o}), 32'd0);
    reset_i = 1'b1;
    step();

    // Host write 0xBEEF to addr 3
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 5'd3; host_data_i = 16'hBEEF;
    step();
    chk("hw_access_strobes", 32'({ram_rd_o, ram_wr_o}), 32'b01);
    chk("hw_access_addr", 32'(ram_addr_o), 32'd3);
    chk("hw_access_data", 32'(ram_data_o), 32'hBEEF);
    chk("hw_access_grant", 32'(grant_o), 32'b01);
    chk("hw_access_noack", 32'({host_ack_o, int_ack_o}), 32'd0);
    step();
    chk("hw_done_ack", 32'({host_ack_o, int_ack_o, ram_wr_o}), 32'b100);
    chk("hw_done_rdata", 32'(host_data_o), 32'd0);
    host_req_i = 1'b0;
    model_mem[3] = 16'hBEEF;
    step();
    chk("hw_idle", 32'({state_o, grant_o, host_ack_o}), 32'd0);
    chk("hw_mem", 32'(mem[3]), 32'hBEEF);

    // Host read addr 3
    host_req_i = 1'b1; host_we_i = 1'b0;
    step();
    chk("hr_access_strobes", 32'({ram_rd_o, ram_wr_o}), 32'b10);
    chk("hr_access_addr", 32'(ram_addr_o), 32'd3);
    step();
    chk("hr_done_ack", 32'(host_ack_o), 32'd1);
    chk("hr_done_rdata", 32'(host_data_o), 32'hBEEF);
    host_req_i = 1'b0;
    step();

    // Internal read of addr 31 (pre-loaded 0x1234)
    int_req_i = 1'b1; int_we_i = 1'b0; int_addr_i = 5'd31;
    step();
    chk("ir_access_grant", 32'(grant_o), 32'b10);
    chk("ir_access_strobes", 32'({ram_rd_o, ram_wr_o}), 32'b10);
    chk("ir_access_addr", 32'(ram_addr_o), 32'd31);
    step();
    chk("ir_done_acks", 32'({host_ack_o, int_ack_o}), 32'b01);
    chk("ir_done_rdata", 32'(int_data_o), 32'h1234);
    chk("ir_host_rdata_kept", 32'(host_data_o), 32'hBEEF);
    chk("ir_done_grant", 32'(grant_o), 32'b10);
    int_req_i = 1'b0;
    step();
    chk("ir_idle_ack", 32'(int_ack_o), 32'd0);

    // Write data hold: host_data_o unchanged by a write, updated only on read DONE
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 5'd5; host_data_i = 16'h5555;
    step();
    step();
    chk("wh_write_ack", 32'(host_ack_o), 32'd1);
    chk("wh_write_rdata", 32'(host_data_o), 32'hBEEF);
    host_req_i = 1'b0;
    model_mem[5] = 16'h5555;
    step();
    host_req_i = 1'b1; host_we_i = 1'b0;
    step();
    chk("wh_read_access_rdata", 32'(host_data_o), 32'hBEEF);
    step();
    chk("wh_read_done_rdata", 32'(host_data_o), 32'h5555);
    host_req_i = 1'b0;
    step();

    // Starvation: host held continuously, int pending -> 4 host grants then int
    for (int g = 0; g < 6; g++) begin
      exp_q.push_back(g == 4 ? 2'b10 : 2'b01);
      starve_exp.push_back(g < 4 ? 4'(g + 1) : 4'd0);
    end
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 5'd3;
    int_req_i = 1'b1; int_we_i = 1'b1; int_addr_i = 5'd7; int_data_i = 16'h7777;
    for (int g = 0; g < 6; g++) begin
      step();
      g_exp = exp_q.pop_front();
      chk($sformatf("starve_grant_%0d", g), 32'(grant_o), 32'(g_exp));
      step();
      chk($sformatf("starve_acks_%0d", g), 32'({host_ack_o, int_ack_o}), 32'({g_exp[0], g_exp[1]}));
      if (g == 4) int_req_i = 1'b0;
      if (g == 5) host_req_i = 1'b0;
      step();
      chk($sformatf("starve_cnt_%0d", g), 32'(starve_cnt_o), 32'(starve_exp.pop_front()));
    end
    model_mem[7] = 16'h7777;
    chk("starve_int_write", 32'(mem[7]), 32'h7777);

    // Reset in the middle of a write access
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 5'd9; host_data_i = 16'hA5A5;
    step();
    chk("mid_rst_pre_wr", 32'(ram_wr_o), 32'd1);
    #1 reset_i = 1'b0;
    #1;
    chk("mid_rst_strobes_grant", 32'({ram_rd_o, ram_wr_o, grant_o}), 32'd0);
    chk("mid_rst_addr_data", 32'({ram_addr_o, ram_data_o}), 32'd0);
    chk("mid_rst_rdata", 32'({host_data_o, int_data_o}), 32'd0);
    step();
    chk("mid_rst_noack", 32'({host_ack_o, int_ack_o, state_o}), 32'd0);
    host_req_i = 1'b0;
    reset_i = 1'b1;
    step();
    chk("mid_rst_idle", 32'({state_o, host_ack_o}), 32'd0);
    chk("mid_rst_mem_kept", 32'(mem[9]), 32'h121E);

    // Random traffic with invariant and read-data checks
    hw = 0; iw = 0; hw_max = 0; iw_max = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      chk("excl", 32'({host_ack_o & int_ack_o, ram_rd_o & ram_wr_o, grant_o[0] & grant_o[1],
                       host_ack_o & ~host_req_i, int_ack_o & ~int_req_i}), 32'd0);
      if (host_req_i) begin
        if (host_ack_o) begin
          if (host_we_i) model_mem[host_addr_i] = host_data_i;
          else chk("rnd_host_rdata", 32'(host_data_o), 32'(model_mem[host_addr_i]));
          chk("rnd_host_wait", 32'(hw <= BOUND), 32'd1);
          hw = 0;
          host_req_i = 1'($urandom_range(0, 1));
          host_we_i = 1'($urandom_range(0, 1));
          host_addr_i = 5'($urandom_range(0, 31));
          host_data_i = 16'($urandom_range(0, 65535));
        end else begin
          hw++;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        host_req_i = 1'b1; hw = 0;
        host_we_i = 1'($urandom_range(0, 1));
        host_addr_i = 5'($urandom_range(0, 31));
        host_data_i = 16'($urandom_range(0, 65535));
      end
      if (int_req_i) begin
        if (int_ack_o) begin
          if (int_we_i) model_mem[int_addr_i] = int_data_i;
          else chk("rnd_int_rdata", 32'(int_data_o), 32'(model_mem[int_addr_i]));
          chk("rnd_int_wait", 32'(iw <= BOUND), 32'd1);
          iw = 0;
          int_req_i = 1'($urandom_range(0, 1));
          int_we_i = 1'($urandom_range(0, 1));
          int_addr_i = 5'($urandom_range(0, 31));
          int_data_i = 16'($urandom_range(0, 65535));
        end else begin
          iw++;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        int_req_i = 1'b1; iw = 0;
        int_we_i = 1'($urandom_range(0, 1));
        int_addr_i = 5'($urandom_range(0, 31));
        int_data_i = 16'($urandom_range(0, 65535));
      end
      if (hw > hw_max) hw_max = hw;
      if (iw > iw_max) iw_max = iw;
    end
    chk("rnd_max_wait", 32'(hw_max <= BOUND && iw_max <= BOUND), 32'd1);
    host_req_i = 1'b0;
    int_req_i = 1'b0;
    repeat (4) step();
    chk("final_idle", 32'({state_o, grant_o, ram_rd_o, ram_wr_o}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
